// File: rtl/ibr128_pkg.sv
// Shared types and constants for the IBR128 stream controller and its output FIFO.
package ibr128_pkg;

   localparam int BLOCK_W = 128;
   localparam int KEY_W   = 64;

   localparam logic [1:0] SOM_ECB = 2'd0;
   localparam logic [1:0] SOM_CBC = 2'd1;
   localparam logic [1:0] SOM_CTR = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DROP = 2'd2,
      ERR  = 2'd3
   } ctrl_state_e;

   typedef struct packed {
      logic               last;
      logic [BLOCK_W-1:0] data;
   } fifo_word_t;

   // A block opens a message when flagged, or when no message is currently open.
   function automatic logic first_block(input logic in_first, input logic msg_open);
      return in_first | ~msg_open;
   endfunction

endpackage

// File: rtl/ibr128_out_fifo.sv
// Two-entry first-word-fall-through result buffer; head is visible while count is non-zero.
module ibr128_out_fifo
   import ibr128_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  fifo_word_t push_word_i,
   input  logic       pop_i,
   output logic       valid_o,
   output fifo_word_t head_o,
   output logic [1:0] count_o
);

   fifo_word_t mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       push_ok_s;
   logic       pop_ok_s;

   // Pointer and occupancy next-state; simultaneous push and pop leaves count unchanged.
   always_comb begin
      push_ok_s = push_i && (count_q != 2'd2);
      pop_ok_s  = pop_i && (count_q != 2'd0);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_ok_s) begin
         wr_ptr_d = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_word_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign valid_o = (count_q != 2'd0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ibr128_stream_ctrl.sv
// Host-side initiator for the IBR128 core: one block in flight at a time, per-message
// first-block flag and configuration latch, timeout abort, and a 2-deep result buffer.
module ibr128_stream_ctrl
   import ibr128_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_data,
   input  logic               in_first,
   input  logic               in_last,
   input  logic               cfg_sa,
   input  logic               cfg_encrypt,
   input  logic [1:0]         cfg_som,
   input  logic [BLOCK_W-1:0] cfg_iv,
   input  logic [KEY_W-1:0]   cfg_key0,
   input  logic [KEY_W-1:0]   cfg_key1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_data,
   output logic               out_last,
   output logic               core_enable,
   output logic               core_fb,
   output logic               core_sa,
   output logic               core_encrypt,
   output logic [1:0]         core_som,
   output logic [BLOCK_W-1:0] core_text,
   output logic [BLOCK_W-1:0] core_iv,
   output logic [KEY_W-1:0]   core_key0,
   output logic [KEY_W-1:0]   core_key1,
   input  logic [BLOCK_W-1:0] core_result,
   input  logic               core_ready,
   output logic               busy,
   output logic               err,
   input  logic               err_clr,
   output logic [CNT_W-1:0]   block_count
);

   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   ctrl_state_e        state_q, state_d;
   logic               enable_q, enable_d;
   logic               fb_q, fb_d;
   logic               sa_q, sa_d;
   logic               enc_q, enc_d;
   logic [1:0]         som_q, som_d;
   logic [BLOCK_W-1:0] text_q, text_d;
   logic [BLOCK_W-1:0] iv_q, iv_d;
   logic [KEY_W-1:0]   key0_q, key0_d;
   logic [KEY_W-1:0]   key1_q, key1_d;
   logic               pend_last_q, pend_last_d;
   logic               msg_open_q, msg_open_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;

   logic               in_ready_s;
   logic               accept_s;
   logic               fb_s;
   logic               push_s;
   logic               pop_s;
   logic               fifo_valid_s;
   logic [1:0]         fifo_count_s;
   fifo_word_t         push_word_s;
   fifo_word_t         head_s;

   assign in_ready_s  = (state_q == IDLE) && (fifo_count_s != 2'd2) && !err_q;
   assign accept_s    = in_valid && in_ready_s;
   assign fb_s        = first_block(in_first, msg_open_q);
   assign pop_s       = fifo_valid_s && out_ready;
   assign push_word_s = '{last: pend_last_q, data: core_result};

   // Controller next-state: issue, capture, drop-wait and timeout handling.
   always_comb begin
      state_d     = state_q;
      enable_d    = enable_q;
      fb_d        = fb_q;
      sa_d        = sa_q;
      enc_d       = enc_q;
      som_d       = som_q;
      text_d      = text_q;
      iv_d        = iv_q;
      key0_d      = key0_q;
      key1_d      = key1_q;
      pend_last_d = pend_last_q;
      msg_open_d  = msg_open_q;
      err_d       = err_clr ? 1'b0 : err_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      push_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               text_d      = in_data;
               pend_last_d = in_last;
               fb_d        = fb_s;
               enable_d    = 1'b1;
               timer_d     = '0;
               state_d     = RUN;
               // Configuration only moves on a message boundary.
               if (fb_s) begin
                  sa_d   = cfg_sa;
                  enc_d  = cfg_encrypt;
                  som_d  = cfg_som;
                  iv_d   = cfg_iv;
                  key0_d = cfg_key0;
                  key1_d = cfg_key1;
               end else begin
                  sa_d   = sa_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (core_ready) begin
               push_s     = 1'b1;
               cnt_d      = cnt_q + CNT_W'(1);
               msg_open_d = !pend_last_q;
               enable_d   = 1'b0;
               state_d    = DROP;
            end else if (timer_q == TMR_LAST) begin
               err_d      = 1'b1;
               enable_d   = 1'b0;
               msg_open_d = 1'b0;
               state_d    = ERR;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         DROP: begin
            if (!core_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end
         ERR: begin
            if (err_clr) begin
               state_d = IDLE;
            end else begin
               state_d = ERR;
            end
         end
         default: begin
            state_d  = IDLE;
            enable_d = 1'b0;
         end
      endcase
   end

   // Controller state and core-facing registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         enable_q    <= 1'b0;
         fb_q        <= 1'b0;
         sa_q        <= 1'b0;
         enc_q       <= 1'b0;
         som_q       <= 2'd0;
         text_q      <= '0;
         iv_q        <= '0;
         key0_q      <= '0;
         key1_q      <= '0;
         pend_last_q <= 1'b0;
         msg_open_q  <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         enable_q    <= enable_d;
         fb_q        <= fb_d;
         sa_q        <= sa_d;
         enc_q       <= enc_d;
         som_q       <= som_d;
         text_q      <= text_d;
         iv_q        <= iv_d;
         key0_q      <= key0_d;
         key1_q      <= key1_d;
         pend_last_q <= pend_last_d;
         msg_open_q  <= msg_open_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
      end
   end

   ibr128_out_fifo u_fifo (
      .clk_i       (Clk),
      .rst_i       (Rst),
      .push_i      (push_s),
      .push_word_i (push_word_s),
      .pop_i       (pop_s),
      .valid_o     (fifo_valid_s),
      .head_o      (head_s),
      .count_o     (fifo_count_s)
   );

   assign in_ready     = in_ready_s;
   assign out_valid    = fifo_valid_s;
   assign out_data     = head_s.data;
   assign out_last     = head_s.last;
   assign core_enable  = enable_q;
   assign core_fb      = fb_q;
   assign core_sa      = sa_q;
   assign core_encrypt = enc_q;
   assign core_som     = som_q;
   assign core_text    = text_q;
   assign core_iv      = iv_q;
   assign core_key0    = key0_q;
   assign core_key1    = key1_q;
   assign busy         = (state_q != IDLE);
   assign err          = err_q;
   assign block_count  = cnt_q;

endmodule

// File: tb/tb_ibr128_stream_ctrl.sv
// Randomized bench for ibr128_stream_ctrl with a transaction-level model and a per-cycle compare.
module tb_ibr128_stream_ctrl;

   localparam int TO = 16;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         in_valid = 1'b0, in_ready, in_first = 1'b0, in_last = 1'b0;
   logic [127:0] in_data = 128'd0;
   logic         cfg_sa = 1'b0, cfg_encrypt = 1'b0;
   logic [1:0]   cfg_som = 2'd0;
   logic [127:0] cfg_iv = 128'd0;
   logic [63:0]  cfg_key0 = 64'd0, cfg_key1 = 64'd0;
   logic         out_valid, out_ready = 1'b1, out_last;
   logic [127:0] out_data;
   logic         core_enable, core_fb, core_sa, core_encrypt;
   logic [1:0]   core_som;
   logic [127:0] core_text, core_iv;
   logic [63:0]  core_key0, core_key1;
   logic [127:0] core_result = 128'd0;
   logic         core_ready = 1'b0;
   logic         busy, err, err_clr = 1'b0;
   logic [15:0]  block_count;

   always #5 Clk = ~Clk;

   ibr128_stream_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .Clk(Clk), .Rst(Rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first(in_first), .in_last(in_last),
      .cfg_sa(cfg_sa), .cfg_encrypt(cfg_encrypt), .cfg_som(cfg_som),
      .cfg_iv(cfg_iv), .cfg_key0(cfg_key0), .cfg_key1(cfg_key1),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .core_enable(core_enable), .core_fb(core_fb), .core_sa(core_sa),
      .core_encrypt(core_encrypt), .core_som(core_som), .core_text(core_text),
      .core_iv(core_iv), .core_key0(core_key0), .core_key1(core_key1),
      .core_result(core_result), .core_ready(core_ready),
      .busy(busy), .err(err), .err_clr(err_clr), .block_count(block_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Stand-in cipher: any mixing of every core input so a wrong field shows up in the result.
   function automatic logic [127:0] core_fn(input logic [127:0] text, input logic [127:0] iv,
                                            input logic [63:0] k1, input logic [63:0] k0,
                                            input logic fb, input logic sa, input logic enc,
                                            input logic [1:0] som);
      return (text ^ iv) + {k1, k0} + {123'd0, fb, sa, enc, som};
   endfunction

   // ---------------- core model (drives just after each rising edge) ----------------
   int cur_lat = 10, lat_cfg = 10, lat_cnt = 0, sticky_cfg = 0, sticky_left = 0;
   bit lat_rand = 1'b0, hang = 1'b0;

   always @(posedge Clk) begin
      #1;
      if (hang) begin
         core_ready = 1'b0;
         lat_cnt    = 0;
      end else if (core_enable) begin
         if (lat_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(1, 12)) : lat_cfg;
         lat_cnt++;
         if (lat_cnt >= cur_lat && !core_ready) begin
            core_ready  = 1'b1;
            core_result = core_fn(core_text, core_iv, core_key1, core_key0,
                                  core_fb, core_sa, core_encrypt, core_som);
            sticky_left = sticky_cfg;
         end
      end else begin
         lat_cnt = 0;
         if (sticky_left > 0) sticky_left--;
         else core_ready = 1'b0;
      end
   end

   int rdy_mode = 0;
   always @(posedge Clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- behavioural model ----------------
   typedef struct packed { logic last; logic [127:0] data; } res_t;
   res_t sb[$];
   res_t r;
   int   m_phase = 0;   // 0 idle, 1 block at core, 2 waiting for ready to fall, 3 halted on timeout
   int   m_wait  = 0;
   bit   m_live = 1'b0, m_err = 1'b0, m_open = 1'b0, m_zero = 1'b0;
   logic [15:0]  m_cnt = 16'd0;
   logic [127:0] m_text = 128'd0, m_iv = 128'd0;
   logic [63:0]  m_k0 = 64'd0, m_k1 = 64'd0;
   logic         m_fb = 1'b0, m_last = 1'b0, m_sa = 1'b0, m_enc = 1'b0;
   logic [1:0]   m_som = 2'd0;
   logic         exp_rdy;
   bit           seen_en = 1'b0, prev_en = 1'b0;
   int           low_run = 0;

   always @(negedge Clk) begin
      exp_rdy = (m_phase == 0) && (sb.size() < 2) && !m_err;
      if (m_live) begin
         chk("in_ready", 128'(in_ready), 128'(exp_rdy));
         chk("core_enable", 128'(core_enable), 128'(m_phase == 1));
         chk("busy", 128'(busy), 128'(m_phase != 0));
         chk("err", 128'(err), 128'(m_err));
         chk("out_valid", 128'(out_valid), 128'(sb.size() > 0));
         chk("block_count", 128'(block_count), 128'(m_cnt));
         if (sb.size() > 0) begin
            chk("out_data", out_data, sb[0].data);
            chk("out_last", 128'(out_last), 128'(sb[0].last));
         end
         if (m_phase == 1) begin
            chk("core_text", core_text, m_text);
            chk("core_fb", 128'(core_fb), 128'(m_fb));
            chk("core_iv", core_iv, m_iv);
            chk("core_keys", {core_key1, core_key0}, {m_k1, m_k0});
            chk("core_mode", 128'({core_sa, core_encrypt, core_som}), 128'({m_sa, m_enc, m_som}));
         end
         if (m_zero) begin
            chk("zero_core", core_text | core_iv | {core_key1, core_key0}, 128'd0);
            chk("zero_flags", 128'({core_fb, core_sa, core_encrypt, core_som, out_last}), 128'd0);
            chk("zero_out", out_data, 128'd0);
         end
         if (core_enable && !prev_en && seen_en) chk("enable_gap", 128'(low_run >= 2), 128'd1);
         if (core_enable) begin
            seen_en = 1'b1;
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_en = core_enable;
      end
      if (Rst) begin
         sb.delete();
         m_phase = 0; m_wait = 0; m_err = 1'b0; m_open = 1'b0; m_cnt = 16'd0;
         m_zero = 1'b1; m_live = 1'b1; seen_en = 1'b0; prev_en = 1'b0;
         m_text = 128'd0; m_iv = 128'd0; m_k0 = 64'd0; m_k1 = 64'd0;
         m_fb = 1'b0; m_last = 1'b0; m_sa = 1'b0; m_enc = 1'b0; m_som = 2'd0;
      end else if (m_live) begin
         if (sb.size() > 0 && out_ready) void'(sb.pop_front());
         case (m_phase)
            1: begin
               if (core_ready) begin
                  r.last = m_last;
                  r.data = core_fn(m_text, m_iv, m_k1, m_k0, m_fb, m_sa, m_enc, m_som);
                  sb.push_back(r);
                  m_cnt++;
                  m_open  = !m_last;
                  m_phase = 2;
               end else begin
                  m_wait++;
                  if (m_wait == TO) begin
                     m_err = 1'b1; m_open = 1'b0; m_phase = 3;
                  end
               end
            end
            2: if (!core_ready) m_phase = 0;
            3: if (err_clr) begin m_err = 1'b0; m_phase = 0; end
            default: begin
               if (in_valid && exp_rdy) begin
                  m_fb   = in_first || !m_open;
                  m_text = in_data;
                  m_last = in_last;
                  if (m_fb) begin
                     m_sa = cfg_sa; m_enc = cfg_encrypt; m_som = cfg_som;
                     m_iv = cfg_iv; m_k0 = cfg_key0; m_k1 = cfg_key1;
                  end
                  m_wait = 0; m_phase = 1; m_zero = 1'b0;
               end
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   bit clr_rand = 1'b0;

   task automatic wait_accept();
      bit got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("accept_timeout", 128'(in_ready), 128'd1);
      @(posedge Clk); #1;
      in_valid = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic drive(input logic [127:0] d, input logic f, input logic l);
      in_data  = d;
      in_first = f;
      in_last  = l;
      in_valid = 1'b1;
      err_clr  = clr_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
   endtask

   task automatic send(input logic [127:0] d, input logic f, input logic l);
      drive(d, f, l);
      wait_accept();
   endtask

   task automatic wait_count(input logic [15:0] n);
      for (int i = 0; i < 300; i++) begin
         if (block_count == n) break;
         @(posedge Clk); #1;
      end
      chk("wait_count", 128'(block_count), 128'(n));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   initial begin
      int en_cycles;
      int len;
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cycles;
      int len;
      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b0;
      cycles(1);
      chk("reset_count", 128'(block_count), 128'd0);
      chk("reset_out_valid", 128'(out_valid), 128'd0);

      // single block message
      cfg_sa = 1'b0; cfg_encrypt = 1'b1; cfg_som = 2'd2;
      cfg_iv   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      cfg_key1 = 64'haabb_0918_2736_ccdd;
      cfg_key0 = 64'h9988_1234_5670_1122;
      send(128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, 1'b1, 1'b1);
      chk("t1_fb", 128'(core_fb), 128'd1);
      chk("t1_som", 128'(core_som), 128'd2);
      wait_count(16'd1);
      chk("t1_count", 128'(block_count), 128'd1);

      // two-block message, configuration changes mid-message must be ignored
      send(128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, 1'b1, 1'b0);
      wait_count(16'd2);
      cfg_iv   = 128'hdead_beef_0000_0000_0000_0000_cafe_f00d;
      cfg_key0 = 64'h0;
      send(128'h3456_7891_2351_6610_4309_acdf_ec12_ba22, 1'b0, 1'b1);
      chk("t2_fb", 128'(core_fb), 128'd0);
      chk("t2_iv", core_iv, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      wait_count(16'd3);

      // output stall across three blocks
      rdy_mode = 1;
      cycles(2);
      send(128'ha1, 1'b1, 1'b0);
      send(128'hb2, 1'b0, 1'b0);
      wait_count(16'd5);
      drive(128'hc3, 1'b0, 1'b1);
      cycles(20);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
      chk("stall_out_valid", 128'(out_valid), 128'd1);
      chk("stall_count", 128'(block_count), 128'd5);
      rdy_mode = 0;
      wait_accept();
      wait_count(16'd6);
      cycles(4);

      // timeout with a core that never answers
      hang = 1'b1;
      send(128'hdd, 1'b1, 1'b0);
      en_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         if (core_enable) en_cycles++;
         if (err) break;
      end
      chk("to_err", 128'(err), 128'd1);
      chk("to_enable", 128'(core_enable), 128'd0);
      chk("to_in_ready", 128'(in_ready), 128'd0);
      chk("to_run_cycles", 128'(en_cycles), 128'd16);
      @(posedge Clk); #1;
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      hang = 1'b0;
      chk("to_cleared", 128'(err), 128'd0);
      send(128'hee, 1'b0, 1'b1);
      chk("to_next_fb", 128'(core_fb), 128'd1);
      wait_count(16'd7);

      // ready held high after capture must yield exactly one result
      sticky_cfg = 4;
      send(128'hff, 1'b1, 1'b1);
      wait_count(16'd8);
      cycles(10);
      chk("sticky_count", 128'(block_count), 128'd8);
      sticky_cfg = 0;

      // randomized messages, latencies, configs and output backpressure
      lat_rand = 1'b1; rdy_mode = 2; clr_rand = 1'b1;
      for (int m = 0; m < 12; m++) begin
         len = int'($urandom_range(1, 4));
         for (int b = 0; b < len; b++) begin
            cfg_sa = 1'($urandom_range(0, 1)); cfg_encrypt = 1'($urandom_range(0, 1));
            cfg_som = 2'($urandom_range(0, 3));
            cfg_iv = {$urandom, $urandom, $urandom, $urandom};
            cfg_key0 = {$urandom, $urandom}; cfg_key1 = {$urandom, $urandom};
            send({$urandom, $urandom, $urandom, $urandom},
                 (b == 0) ? 1'b1 : 1'($urandom_range(0, 7) == 0), b == len - 1);
         end
      end
      clr_rand = 1'b0; lat_rand = 1'b0; rdy_mode = 0;
      cycles(40);

      // reset while a block is at the core
      send(128'h77, 1'b1, 1'b1);
      cycles(3);
      Rst = 1'b1;
      cycles(1);
      Rst = 1'b0;
      chk("rst_enable", 128'(core_enable), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_count", 128'(block_count), 128'd0);
      chk("rst_text", core_text, 128'd0);
      cycles(5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
